amstrad_mmu_gen: RTL and testbench

Parametrised CPC memory management unit: decodes gate-array RMR, PAL MMR and upper-ROM-select I/O writes, and translates the Z80 address into a flat SDRAM address covering lower/upper ROM images, base 64 KB and a configurable RAM expansion of up to 4 MB. It sits between the Z80 bus and the SDRAM controller in the motherboard. Unlike the previous MMU, it has a registered output, a selectable expansion size, and an optional CPC Plus ASIC unlock sequencer with RMR2 lower-ROM relocation.

---
 rtl/amstrad_mmu_gen.sv | 161 ++++++++++++++++
 tb/tb_amstrad_mmu_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/amstrad_mmu_gen.sv
// amstrad_mmu_gen: CPC memory management unit.
// Decodes gate-array RMR, PAL MMR and upper-ROM-select I/O writes and maps the
// Z80 address onto a flat SDRAM address (ROM images, base 64 KB, RAM expansion).
// Optional build macro: AMSTRAD_MMU_PLUS_EN adds the CPC Plus ASIC unlock
// sequencer and RMR2 lower-ROM relocation.
module amstrad_mmu_gen #(
    parameter int PAGE_BITS  = 5,
    parameter int EXT_OFFSET = 3,
    parameter int BASE_PAGE  = 2
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         ram64k,
    input  logic [255:0] rom_map,
    input  logic         mem_WR,
    input  logic         io_WR,
    input  logic [7:0]   D,
    input  logic [15:0]  A,
    output logic [22:0]  ram_A,
    output logic         plus_unlocked
);

    localparam int XB = PAGE_BITS - 3;
    localparam logic [PAGE_BITS-1:0] BASE_PG = PAGE_BITS'(BASE_PAGE);
    localparam logic [PAGE_BITS-1:0] EXT_OFS = PAGE_BITS'(EXT_OFFSET);

    logic                 old_wr;
    logic                 we;
    logic                 rmr_hit, rmr2_sel, mmr_hit, rom_hit;
    logic                 lower_rom_en, upper_rom_en;
    logic [2:0]           ram_map;
    logic [PAGE_BITS-1:0] ram_page;
    logic [PAGE_BITS-1:0] page_next;
    logic [7:0]           rom_bank;
    logic [1:0]           lrom_loc;
    logic [2:0]           lrom_bank;
    logic                 unlocked;
    logic [1:0]           bank;
    logic [8:0]           t_field;

    assign we        = io_WR & ~old_wr;
    assign rmr_hit   = we && (A[15:14] == 2'b01) && (D[7:6] == 2'b10);
    assign mmr_hit   = we && !A[15] && (D[7:6] == 2'b11) && !ram64k;
    assign rom_hit   = we && !A[13];
    assign page_next = {~A[8+XB-1:8], D[5:3]} + EXT_OFS;
    assign bank      = A[15:14];

`ifdef AMSTRAD_MMU_PLUS_EN
    logic [4:0] seq_cnt;
    logic [7:0] seq_byte;

    // Expected unlock byte for the current sequencer position
    always_comb begin
        seq_byte = 8'h00;
        case (seq_cnt)
            5'd0:    seq_byte = 8'hFF;
            5'd1:    seq_byte = 8'h00;
            5'd2:    seq_byte = 8'hFF;
            5'd3:    seq_byte = 8'h77;
            5'd4:    seq_byte = 8'hB3;
            5'd5:    seq_byte = 8'h51;
            5'd6:    seq_byte = 8'hA8;
            5'd7:    seq_byte = 8'hD4;
            5'd8:    seq_byte = 8'h62;
            5'd9:    seq_byte = 8'h39;
            5'd10:   seq_byte = 8'h9C;
            5'd11:   seq_byte = 8'h46;
            5'd12:   seq_byte = 8'h2B;
            5'd13:   seq_byte = 8'h15;
            5'd14:   seq_byte = 8'h8A;
            5'd15:   seq_byte = 8'hCD;
            default: seq_byte = 8'h00;
        endcase
    end

    assign rmr2_sel = unlocked && D[5];

    // ASIC unlock sequencer and RMR2 lower-ROM relocation registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            seq_cnt   <= '0;
            unlocked  <= 1'b0;
            lrom_loc  <= '0;
            lrom_bank <= '0;
        end else begin
            if (we && (A[15:8] == 8'hBC)) begin
                if (seq_cnt == 5'd16) begin
                    unlocked <= (D == 8'hEE);
                    seq_cnt  <= '0;
                end else if (D == seq_byte) begin
                    seq_cnt <= seq_cnt + 5'd1;
                end else begin
                    seq_cnt <= (D == 8'hFF) ? 5'd1 : 5'd0;
                end
            end
            if (rmr_hit && rmr2_sel) begin
                lrom_bank <= D[2:0];
                lrom_loc  <= (D[4:3] == 2'b11) ? 2'b00 : D[4:3];
            end
        end
    end
`else
    assign unlocked  = 1'b0;
    assign rmr2_sel  = 1'b0;
    assign lrom_loc  = 2'b00;
    assign lrom_bank = 3'b000;
`endif

    assign plus_unlocked = unlocked;

    // Write-edge detector and gate-array / PAL / ROM-select registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            old_wr       <= 1'b0;
            lower_rom_en <= 1'b1;
            upper_rom_en <= 1'b1;
            ram_map      <= '0;
            ram_page     <= EXT_OFS;
            rom_bank     <= '0;
        end else begin
            old_wr <= io_WR;
            if (rmr_hit && !rmr2_sel) begin
                lower_rom_en <= ~D[2];
                upper_rom_en <= ~D[3];
            end
            if (mmr_hit) begin
                ram_map  <= D[2:0];
                ram_page <= page_next;
            end
            if (rom_hit)
                rom_bank <= rom_map[D] ? D : 8'h00;
        end
    end

    // Address translation: first matching rule wins
    always_comb begin
        t_field = '0;
        if (lower_rom_en && !mem_WR && (bank == lrom_loc))
            t_field = 9'(lrom_bank);
        else if (upper_rom_en && !mem_WR && (bank == 2'b11))
            t_field = {1'b1, rom_bank};
        else if ((ram_map == 3'b010) ||
                 (((ram_map == 3'b001) || (ram_map == 3'b011)) && (bank == 2'b11)))
            t_field = 9'({ram_page, bank});
        else if ((ram_map == 3'b011) && (bank == 2'b01))
            t_field = 9'({BASE_PG, 2'b11});
        else if (ram_map[2] && (bank == 2'b01))
            t_field = 9'({ram_page, ram_map[1:0]});
        else
            t_field = 9'({BASE_PG, bank});
    end

    // Registered SDRAM address
    always_ff @(posedge CLK) begin
        if (reset)
            ram_A <= '0;
        else
            ram_A <= {t_field, A[13:0]};
    end

endmodule

// File: tb/tb_amstrad_mmu_gen.sv
// tb_amstrad_mmu_gen: directed self-checking bench for amstrad_mmu_gen
// (default parameters PAGE_BITS=5, EXT_OFFSET=3, BASE_PAGE=2).
module tb_amstrad_mmu_gen;

    logic         CLK = 1'b0;
    logic         reset = 1'b1;
    logic         ram64k = 1'b0;
    logic [255:0] rom_map = '0;
    logic         mem_WR = 1'b0;
    logic         io_WR = 1'b0;
    logic [7:0]   D = 8'h00;
    logic [15:0]  A = 16'h0000;
    logic [22:0]  ram_A;
    logic         plus_unlocked;

    int unsigned passes = 0;
    int unsigned total  = 0;

    amstrad_mmu_gen #(.PAGE_BITS(5), .EXT_OFFSET(3), .BASE_PAGE(2)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .ram64k       (ram64k),
        .rom_map      (rom_map),
        .mem_WR       (mem_WR),
        .io_WR        (io_WR),
        .D            (D),
        .A            (A),
        .ram_A        (ram_A),
        .plus_unlocked(plus_unlocked)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_addr(input string tag, input logic [22:0] exp);
        total++;
        assert (ram_A === exp) passes++;
        else $error("FAIL %s: ram_A=%06h expected %06h", tag, ram_A, exp);
    endtask

    task automatic chk_unl(input string tag, input logic exp);
        total++;
        assert (plus_unlocked === exp) passes++;
        else $error("FAIL %s: plus_unlocked=%0b expected %0b", tag, plus_unlocked, exp);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        A = a; D = d; io_WR = 1'b1;
        step();
        io_WR = 1'b0;
        step();
    endtask

    task automatic rd(input logic [15:0] a, input logic wr, input string tag,
                      input logic [22:0] exp);
        A = a; mem_WR = wr;
        step();
        chk_addr(tag, exp);
    endtask

`ifdef AMSTRAD_MMU_PLUS_EN
    logic [7:0] seq [16] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
                             8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD};

    task automatic send_seq(input int unsigned first, input int unsigned last);
        for (int unsigned i = first; i <= last; i++)
            io_write(16'hBC00, seq[i]);
    endtask
`endif

    initial begin
        // reset
        step(); step();
        chk_addr("reset_ram_A", 23'h000000);
        chk_unl("reset_unlocked", 1'b0);
        reset = 1'b0;

        // power-up mapping: lower ROM at bank 0, upper ROM 0 at bank 3
        rd(16'h0123, 1'b0, "lrom_read",     23'h000123);
        rd(16'hC000, 1'b0, "urom0_read",    23'h400000);
        rd(16'h4000, 1'b0, "base_bank1",    23'h024000);
        rd(16'h8000, 1'b0, "base_bank2",    23'h028000);
        rd(16'h0000, 1'b1, "wr_bank0",      23'h020000);
        rd(16'hC000, 1'b1, "wr_bank3",      23'h02C000);

        // MMR C4 at 7F00: map 100, page 3
        io_write(16'h7F00, 8'hC4);
        rd(16'h4000, 1'b0, "mmr_c4_bank1", 23'h030000);
        rd(16'h8000, 1'b0, "mmr_c4_bank2", 23'h028000);
        rd(16'hC000, 1'b0, "mmr_c4_urom",  23'h400000);

        // MMR C7 at 7C00: extra page bits 11, page 27, map 111
        io_write(16'h7C00, 8'hC7);
        rd(16'h4000, 1'b0, "mmr_c7_bank1", 23'h1BC000);
        rd(16'hC000, 1'b1, "mmr_c7_bank3", 23'h02C000);

        // MMR F3 at 7C00: page (30+3) mod 32 = 1, map 011
        io_write(16'h7C00, 8'hF3);
        rd(16'hC000, 1'b1, "wrap_bank3",   23'h01C000);
        rd(16'h4000, 1'b0, "map3_bank1",   23'h02C000);

        // upper ROM select
        rom_map[7] = 1'b1;
        io_write(16'hDF00, 8'h07);
        rd(16'hC000, 1'b0, "urom7_present", 23'h41C000);
        rom_map[7] = 1'b0;
        io_write(16'hDF00, 8'h07);
        rd(16'hC000, 1'b0, "urom7_absent",  23'h400000);

        // RMR 8C: both ROMs off
        io_write(16'h7F00, 8'hC0);
        io_write(16'h7F00, 8'h8C);
        rd(16'h0000, 1'b1, "roms_off_wr",   23'h020000);
        rd(16'h0010, 1'b0, "roms_off_rd0",  23'h020010);
        rd(16'hC000, 1'b0, "roms_off_rd3",  23'h02C000);

        // RMR AB while locked: lower on, upper off
        io_write(16'h7F00, 8'hAB);
        rd(16'h0000, 1'b0, "rmr_ab_lrom",   23'h000000);
        rd(16'hC000, 1'b0, "rmr_ab_urom",   23'h02C000);

        // ram64k blocks MMR
        ram64k = 1'b1;
        io_write(16'h7F00, 8'hC2);
        ram64k = 1'b0;
        rd(16'h4000, 1'b0, "ram64k_block",  23'h024000);

        // io_WR held high: only the first byte (C2) is taken
        A = 16'h7F00; D = 8'hC2; io_WR = 1'b1;
        step();
        D = 8'hC4;
        repeat (9) step();
        rd(16'h4000, 1'b0, "hold_one_event", 23'h034000);

        // reset pulse during the hold
        reset = 1'b1;
        step();
        chk_addr("hold_reset_ram_A", 23'h000000);
        reset = 1'b0; io_WR = 1'b0;
        step();
        rd(16'h4000, 1'b0, "hold_reset_map", 23'h024000);

        // reset wins over a write event in the same cycle
        io_write(16'h7F00, 8'hC4);
        rd(16'h4000, 1'b0, "pre_prio_map",   23'h030000);
        A = 16'h7F00; D = 8'hC2; io_WR = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; io_WR = 1'b0;
        step();
        rd(16'h4000, 1'b0, "reset_priority", 23'h024000);

`ifdef AMSTRAD_MMU_PLUS_EN
        // stray 00 at S=5 restarts the sequence
        send_seq(0, 4);
        io_write(16'hBC00, 8'h00);
        send_seq(5, 15);
        io_write(16'hBC00, 8'hEE);
        chk_unl("stray_restart", 1'b0);

        // complete sequence ending in 00 stays locked
        send_seq(0, 15);
        io_write(16'hBC00, 8'h00);
        chk_unl("end_00_locked", 1'b0);

        // complete sequence ending in EE unlocks
        send_seq(0, 15);
        io_write(16'hBC00, 8'hEE);
        chk_unl("unlock_ee", 1'b1);

        // RMR2 AB: lower ROM bank 3 relocated to 4000
        io_write(16'h7F00, 8'hAB);
        rd(16'h4000, 1'b0, "rmr2_bank1",   23'h00C000);
        rd(16'h0000, 1'b0, "rmr2_bank0",   23'h020000);

        // RMR2 BD: location 11 folds to 00, bank 5
        io_write(16'h7F00, 8'hBD);
        rd(16'h0000, 1'b0, "rmr2_loc11",   23'h014000);
`else
        // sequencer absent: the unlock bytes have no effect
        io_write(16'hBC00, 8'hFF);
        io_write(16'hBC00, 8'hEE);
        chk_unl("no_plus_locked", 1'b0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
